// File: rtl/sysarr_stream_ctrl_if.sv
// Handshake and bus bundle between the stream controller, its byte source/sink
// and the 3x3 systolic array.
interface sysarr_stream_ctrl_if #(
   parameter int ELEM_W = 8
);
   logic [ELEM_W-1:0]   in_data;
   logic                in_valid;
   logic                in_ready;

   logic [ELEM_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;

   logic [9*ELEM_W-1:0] arr_A;
   logic [9*ELEM_W-1:0] arr_B;
   logic                arr_start;
   logic                arr_valid;
   logic [9*ELEM_W-1:0] arr_C;

   // controller side
   modport slave (
      input  in_data, in_valid, out_ready, arr_valid, arr_C,
      output in_ready, out_data, out_valid, out_last, arr_A, arr_B, arr_start
   );

   // source/sink/array side
   modport master (
      output in_data, in_valid, out_ready, arr_valid, arr_C,
      input  in_ready, out_data, out_valid, out_last, arr_A, arr_B, arr_start
   );
endinterface

// File: rtl/sysarr_stream_ctrl.sv
// Byte-stream loader/drainer around the 3x3 systolic array: packs 18 input
// elements into arr_A/arr_B, runs one job, streams 9 result elements back out.
// Optional START watchdog is enabled by defining SYSARR_TIMEOUT_EN.
//
// state | meaning
// LOAD  | accepting elements 0..17 into arr_A (0..8) and arr_B (9..17)
// START | arr_start high, waiting for arr_valid
// DRAIN | streaming captured result slots 0..8, out_last on slot 8
module sysarr_stream_ctrl #(
   parameter int ELEM_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   sysarr_stream_ctrl_if.slave bus,
   output logic                busy,
   output logic                err
);

   localparam int MAT_W = 9 * ELEM_W;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q;
   logic [4:0]          idx_q;
   logic [3:0]          k_q;
   logic [MAT_W-1:0]    a_q;
   logic [MAT_W-1:0]    b_q;
   logic [MAT_W-1:0]    cap_q;
   logic                start_q;
   logic                out_valid_q;
   logic                out_last_q;
   logic [ELEM_W-1:0]   out_data_q;

`ifdef SYSARR_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0]    tmr_q;
   logic                err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_W-1:0] mat,
                                                 input logic [3:0] slot);
      elem_at = '0;
      for (int i = 0; i < 9; i++) begin
         if (slot == 4'(i)) elem_at = mat[ELEM_W*i +: ELEM_W];
      end
   endfunction

   assign bus.in_ready  = (state_q == LOAD);
   assign busy          = (state_q != LOAD);
   assign bus.arr_A     = a_q;
   assign bus.arr_B     = b_q;
   assign bus.arr_start = start_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_data  = out_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         idx_q       <= '0;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cap_q       <= '0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
`ifdef SYSARR_TIMEOUT_EN
         tmr_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            LOAD: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < 9; i++) begin
                     if (idx_q == 5'(i))     a_q[ELEM_W*i +: ELEM_W] <= bus.in_data;
                     if (idx_q == 5'(i + 9)) b_q[ELEM_W*i +: ELEM_W] <= bus.in_data;
                  end
                  if (idx_q == 5'd17) begin
                     idx_q   <= '0;
                     start_q <= 1'b1;
                     state_q <= START;
`ifdef SYSARR_TIMEOUT_EN
                     tmr_q   <= TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                  end else begin
                     idx_q <= idx_q + 5'd1;
                  end
               end
            end

            START: begin
               if (bus.arr_valid) begin
                  cap_q       <= bus.arr_C;
                  start_q     <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= bus.arr_C[ELEM_W-1:0];
                  out_last_q  <= 1'b0;
                  k_q         <= '0;
                  state_q     <= DRAIN;
               end
`ifdef SYSARR_TIMEOUT_EN
               // Watchdog expiry still emits a full zero frame to keep framing.
               else if (tmr_q == '0) begin
                  cap_q       <= '0;
                  start_q     <= 1'b0;
                  err_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  out_data_q  <= '0;
                  out_last_q  <= 1'b0;
                  k_q         <= '0;
                  state_q     <= DRAIN;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
`endif
            end

            DRAIN: begin
               if (bus.out_ready) begin
                  if (k_q == 4'd8) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     out_data_q  <= '0;
                     k_q         <= '0;
                     state_q     <= LOAD;
                  end else begin
                     k_q        <= k_q + 4'd1;
                     out_data_q <= elem_at(cap_q, k_q + 4'd1);
                     out_last_q <= (k_q == 4'd7);
                  end
               end
            end

            default: state_q <= LOAD;
         endcase
      end
   end

endmodule
